// File: rtl/sqrt_pkg.sv
// ============================================================================
//  Module   : sqrt_pkg
//  Purpose  : Shared state encoding, default widths and width helper for the
//             shared square-root sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sqrt_pkg;

    localparam int c_default_size      = 108;
    localparam int c_default_half_size = 54;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Index/counter widths never collapse to zero bits, even for n <= 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : sqrt_pkg

`default_nettype wire

// File: rtl/sqrt_rr_arbiter.sv
// ============================================================================
//  Module   : sqrt_rr_arbiter
//  Purpose  : Combinational round-robin pick, searching upward from rr_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any_req
);

    logic [PW:0] w_sum;
    logic [PW-1:0] w_idx;

    // The extra bit in w_sum lets the wrap work for non-power-of-two NREQ.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NREQ))
                w_sum = w_sum - (PW+1)'(NREQ);
            w_idx = w_sum[PW-1:0];
            if (!any_req && req[w_idx]) begin
                any_req   = 1'b1;
                grant_idx = w_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any_req)
            grant[grant_idx] = 1'b1;
    end

endmodule : sqrt_rr_arbiter

`default_nettype wire

// File: rtl/sqrt_share_ctrl.sv
// ============================================================================
//  Module   : sqrt_share_ctrl
//  Purpose  : Shares one external combinational square-root array among NREQ
//             requesters with round-robin arbitration and a settle window.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_share_ctrl
    import sqrt_pkg::*;
#(
    parameter int SIZE          = c_default_size,
    parameter int HALF_SIZE     = c_default_half_size,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_data,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [HALF_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic [SIZE-1:0]      core_p,
    input  logic [HALF_SIZE-1:0] core_u
);

    localparam int PW = clog2_min1(NREQ);
    localparam int CW = clog2_min1(SETTLE_CYCLES) + 1;

    localparam logic [CW-1:0] c_cnt_load = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] c_last_idx = PW'(NREQ - 1);

    if ((SIZE % 2) != 0) begin : g_chk_size
        $error("sqrt_share_ctrl: SIZE must be even");
    end
    if (HALF_SIZE != SIZE / 2) begin : g_chk_half
        $error("sqrt_share_ctrl: HALF_SIZE must equal SIZE/2");
    end
    if (NREQ < 2) begin : g_chk_nreq
        $error("sqrt_share_ctrl: NREQ must be at least 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_chk_settle
        $error("sqrt_share_ctrl: SETTLE_CYCLES must be at least 1");
    end

    state_t                r_state;
    logic [SIZE-1:0]       r_op;
    logic [HALF_SIZE-1:0]  r_res;
    logic [PW-1:0]         r_owner;
    logic [PW-1:0]         r_rr_ptr;
    logic [CW-1:0]         r_cnt;

    logic [NREQ-1:0]       w_grant_oh;
    logic [PW-1:0]         w_grant_idx;
    logic                  w_any;
    logic [SIZE-1:0]       w_sel_data;
    logic                  w_owner_ready;

    sqrt_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any_req   (w_any)
    );

    assign w_sel_data    = req_data[w_grant_idx*SIZE +: SIZE];
    assign w_owner_ready = rsp_ready[r_owner];

    assign req_ready = (r_state == IDLE) ? w_grant_oh : '0;
    assign busy      = (r_state != IDLE);
    assign core_p    = r_op;
    assign rsp_data  = r_res;

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP)
            rsp_valid[r_owner] = 1'b1;
    end

    // r_op only loads on the IDLE handshake so the array input cannot move
    // while its output is still settling or waiting to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_res    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op    <= w_sel_data;
                        r_owner <= w_grant_idx;
                        r_cnt   <= c_cnt_load;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_res   <= core_u;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_owner_ready) begin
                        r_rr_ptr <= (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : sqrt_share_ctrl

`default_nettype wire

// File: tb/tb_sqrt_share_ctrl.sv
// ============================================================================
//  Module   : tb_sqrt_share_ctrl
//  Purpose  : Directed self-checking bench for sqrt_share_ctrl with a
//             behavioural square-root array on core_p/core_u.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_share_ctrl;

    localparam int SIZE          = 8;
    localparam int HALF_SIZE     = 4;
    localparam int NREQ          = 4;
    localparam int SETTLE_CYCLES = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_data;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [HALF_SIZE-1:0] rsp_data;
    logic                 busy;
    logic [SIZE-1:0]      core_p;
    logic [HALF_SIZE-1:0] core_u;

    int n_checks = 0;
    int n_fail   = 0;

    sqrt_share_ctrl #(
        .SIZE          (SIZE),
        .HALF_SIZE     (HALF_SIZE),
        .NREQ          (NREQ),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .core_p    (core_p),
        .core_u    (core_u)
    );

    function automatic logic [HALF_SIZE-1:0] isqrt(input logic [SIZE-1:0] p);
        logic [HALF_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i * i <= int'(p)) r = HALF_SIZE'(i);
        return r;
    endfunction

    always_comb core_u = isqrt(core_p);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input int p);
        req_data[k*SIZE +: SIZE] = SIZE'(p);
        req_valid[k]             = 1'b1;
    endtask

    // Called just after a falling edge; returns the first nonzero req_ready.
    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready != '0) begin
                g = req_ready;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Called in cycle T+1 after the handshake; lat is the cycle offset from T.
    task automatic wait_rsp(output logic [NREQ-1:0] v, output int lat);
        v   = '0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (rsp_valid != '0) begin
                v   = rsp_valid;
                lat = n;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data",  rsp_data,  0);
        chk("rst busy",      busy,      0);
        chk("rst core_p",    core_p,    0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single transaction with rsp_ready held high; starts at a falling edge.
    task automatic run_single(input int k, input int p, input int root);
        logic [NREQ-1:0] g, v;
        int lat;
        set_req(k, p);
        wait_grant(g);
        chk("single grant", g, 64'(1 << k));
        @(negedge clk);
        req_valid[k] = 1'b0;
        #1;
        chk("single core_p", core_p, 64'(p));
        chk("single busy", busy, 1);
        wait_rsp(v, lat);
        chk("single rsp_valid", v, 64'(1 << k));
        chk("single rsp_data", rsp_data, 64'(root));
        chk("single latency", lat, 4);
        @(negedge clk);
        #1;
        chk("single busy low", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [NREQ-1:0] g, v, seen;
        int lat;
        int ord2 [2]  = '{0, 2};
        int root2 [2] = '{6, 8};
        int roots [4] = '{2, 3, 5, 7};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '1;
        do_reset();

        // single request and boundary radicands
        run_single(0, 144, 12);
        run_single(1, 0, 0);
        run_single(2, 1, 1);
        run_single(3, 255, 15);
        run_single(0, 15, 3);
        run_single(1, 16, 4);

        // contention from reset
        do_reset();
        set_req(0, 4);
        set_req(1, 9);
        set_req(2, 25);
        set_req(3, 49);
        for (int j = 0; j < 4; j++) begin
            wait_grant(g);
            chk("cont grant", g, 64'(1 << j));
            @(negedge clk);
            req_valid[j] = 1'b0;
            wait_rsp(v, lat);
            chk("cont rsp_valid", v, 64'(1 << j));
            chk("cont rsp_data", rsp_data, 64'(roots[j]));
            @(negedge clk);
        end
        set_req(0, 36);
        set_req(2, 64);
        for (int j = 0; j < 2; j++) begin
            wait_grant(g);
            chk("rerq grant", g, 64'(1 << ord2[j]));
            @(negedge clk);
            req_valid[ord2[j]] = 1'b0;
            wait_rsp(v, lat);
            chk("rerq rsp_valid", v, 64'(1 << ord2[j]));
            chk("rerq rsp_data", rsp_data, 64'(root2[j]));
            @(negedge clk);
        end

        // backpressure on requester 1 with requester 3 waiting
        rsp_ready = 4'b1101;
        set_req(1, 100);
        wait_grant(g);
        chk("bp grant", g, 64'(4'b0010));
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(3, 36);
        wait_rsp(v, lat);
        chk("bp rsp_valid", v, 64'(4'b0010));
        chk("bp rsp_data", rsp_data, 10);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("bp hold valid", rsp_valid, 64'(4'b0010));
            chk("bp hold data", rsp_data, 10);
            chk("bp hold core_p", core_p, 100);
            chk("bp req_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = '1;
        #1;
        chk("bp last req_ready", req_ready, 0);
        @(negedge clk);
        #1;
        chk("bp rsp released", rsp_valid, 0);
        chk("bp grant3", req_ready, 64'(4'b1000));
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp(v, lat);
        chk("bp rsp3 valid", v, 64'(4'b1000));
        chk("bp rsp3 data", rsp_data, 6);
        @(negedge clk);

        // operand stability after the handshake
        set_req(0, 64);
        wait_grant(g);
        chk("stab grant", g, 64'(4'b0001));
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_data[7:0] = 8'd200;
        #1;
        chk("stab core_p", core_p, 64);
        wait_rsp(v, lat);
        chk("stab rsp_data", rsp_data, 8);
        chk("stab core_p rsp", core_p, 64);
        @(negedge clk);
        @(negedge clk);
        run_single(0, 200, 14);

        // asynchronous reset during SETTLE
        set_req(2, 81);
        wait_grant(g);
        chk("mrst grant", g, 64'(4'b0100));
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst busy pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst busy", busy, 0);
        chk("mrst core_p", core_p, 0);
        chk("mrst rsp_valid", rsp_valid, 0);
        chk("mrst rsp_data", rsp_data, 0);
        chk("mrst req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            seen = seen | rsp_valid;
        end
        chk("mrst no rsp", seen, 0);
        @(negedge clk);
        run_single(1, 121, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sqrt_share_ctrl

`default_nettype wire
